// File: rtl/sound_freq_detect_pkg.sv
// Shared definitions for the sound input detectors: counter width, FSM
// encoding and the period constants derived from clock and tone frequency.
package sound_defs;

    localparam int CLK_HZ_DEFAULT = 50_000_000;
    localparam int CNT_W          = 18;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    function automatic int nominalPeriod(input int clkHz, input int freq);
        return clkHz / freq;
    endfunction

    // Edges closer than a quarter of the nominal period are treated as glitches.
    function automatic int minPeriod(input int clkHz, input int freq);
        return nominalPeriod(clkHz, freq) / 4;
    endfunction

    function automatic int timeoutClocks(input int clkHz, input int freq);
        return 2 * nominalPeriod(clkHz, freq);
    endfunction

endpackage

// File: rtl/sound_freq_detect_sync_rise.sv
// Two-flop synchronizer plus edge flop for an asynchronous pin; emits a
// registered one-cycle pulse on each rising edge of the input.
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic s1_q, s2_q, s3_q, rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= async_in;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/sound_freq_detect.sv
// Measures the period between rising edges of an asynchronous tone input and
// flags lock once LOCK_N consecutive periods fall within TOL of the nominal.
module sound_freq_detect
    import sound_defs::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT,
    parameter int FREQ   = 1000,
    parameter int TOL    = 500,
    parameter int LOCK_N = 4
) (
    input  logic             clk_50M,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             freq_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             tone_detected,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] NOMINAL_C = CNT_W'(nominalPeriod(CLK_HZ, FREQ));
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(minPeriod(CLK_HZ, FREQ));
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(timeoutClocks(CLK_HZ, FREQ));
    localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);
    localparam logic [3:0]       LOCK_C    = 4'(LOCK_N);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [3:0]       matchCnt_q, matchCnt_d;
    logic             valid_q, valid_d;
    logic             tone_q, tone_d;
    logic             timeout_q, timeout_d;

    logic             rise;
    logic [CNT_W-1:0] candidate;
    logic [CNT_W-1:0] cntInc;
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]   absDiff;
    logic             periodMatch;

    sync_rise u_sync (
        .clk      (clk_50M),
        .rst_n    (reset_n),
        .async_in (freq_in),
        .rise     (rise)
    );

    // One extra bit on the difference keeps the magnitude compare free of wrap.
    assign candidate   = cnt_q + CNT_W'(1);
    assign cntInc      = (cnt_q == '1) ? cnt_q : candidate;
    assign diff        = signed'({1'b0, candidate}) - signed'({1'b0, NOMINAL_C});
    assign absDiff     = diff[CNT_W] ? unsigned'(-diff) : unsigned'(diff);
    assign periodMatch = (absDiff <= TOL_C);

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            matchCnt_q <= '0;
            valid_q    <= 1'b0;
            tone_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            matchCnt_q <= matchCnt_d;
            valid_q    <= valid_d;
            tone_q     <= tone_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        matchCnt_d = matchCnt_q;
        valid_d    = 1'b0;
        tone_d     = tone_q;
        timeout_d  = timeout_q;

        // Dropping enable wins over any edge seen in the same cycle.
        if (!enable) begin
            state_d    = IDLE;
            cnt_d      = '0;
            matchCnt_d = '0;
            tone_d     = 1'b0;
            timeout_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d      = '0;
                    matchCnt_d = '0;
                    tone_d     = 1'b0;
                    timeout_d  = 1'b0;
                    state_d    = ARM;
                end
                ARM: begin
                    cnt_d = cntInc;
                    if (rise) begin
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                        state_d   = MEASURE;
                    end
                end
                MEASURE: begin
                    cnt_d = cntInc;
                    if (rise && (candidate >= MIN_C)) begin
                        period_d  = candidate;
                        valid_d   = 1'b1;
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                        if (periodMatch) begin
                            matchCnt_d = (matchCnt_q >= LOCK_C) ? LOCK_C : matchCnt_q + 4'd1;
                            tone_d     = (matchCnt_d == LOCK_C);
                        end else begin
                            matchCnt_d = '0;
                            tone_d     = 1'b0;
                        end
                    end else if (candidate == TIMEOUT_C) begin
                        timeout_d  = 1'b1;
                        tone_d     = 1'b0;
                        matchCnt_d = '0;
                        state_d    = ARM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign period        = period_q;
    assign period_valid  = valid_q;
    assign tone_detected = tone_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_sound_freq_detect.sv
// Directed bench for sound_freq_detect using a scaled tone: NOMINAL = 200,
// MIN_PERIOD = 50, TIMEOUT = 400, TOL = 2, LOCK_N = 4.
module tb_sound_freq_detect;

    logic        clk_50M;
    logic        reset_n;
    logic        enable;
    logic        freq_in;
    logic [17:0] period;
    logic        period_valid;
    logic        tone_detected;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    int cycle = 0;
    int strobeCount = 0;
    int lastPeriod = 0;
    int lastTone = 0;
    int lastStrobeCycle = 0;
    int timeoutCycle = 0;
    logic prevTimeout = 1'b0;

    int riseCycle = 0;
    int baseCount = 0;

    sound_freq_detect #(
        .CLK_HZ (50_000_000),
        .FREQ   (250_000),
        .TOL    (2),
        .LOCK_N (4)
    ) dut (
        .clk_50M       (clk_50M),
        .reset_n       (reset_n),
        .enable        (enable),
        .freq_in       (freq_in),
        .period        (period),
        .period_valid  (period_valid),
        .tone_detected (tone_detected),
        .timeout       (timeout)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cycle <= cycle + 1;

    // Strobe and timeout observer, sampled on the falling edge.
    always @(negedge clk_50M) begin
        if (period_valid === 1'b1) begin
            strobeCount     = strobeCount + 1;
            lastPeriod      = int'(period);
            lastTone        = int'(tone_detected);
            lastStrobeCycle = cycle;
        end
        if (timeout === 1'b1 && prevTimeout !== 1'b1)
            timeoutCycle = cycle;
        prevTimeout = timeout;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_50M);
            #1;
        end
    endtask

    // One full input period: rising edge now, next edge gap clocks later.
    task automatic applyStimulus(input int gap);
        riseCycle = cycle;
        freq_in = 1'b1;
        step(gap / 2);
        freq_in = 1'b0;
        step(gap - gap / 2);
    endtask

    task automatic glitchPeriod(input int gap);
        riseCycle = cycle;
        freq_in = 1'b1;
        step(3);
        freq_in = 1'b0;
        step(3);
        freq_in = 1'b1;
        step(3);
        freq_in = 1'b0;
        step(gap - 9);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        freq_in = 1'b0;

        // Reset held with the input toggling
        for (int i = 0; i < 6; i++) begin
            freq_in = ~freq_in;
            step(3);
        end
        freq_in = 1'b0;
        checkOutput("reset_period", 32'(period), 32'd0);
        checkOutput("reset_valid", 32'(period_valid), 32'd0);
        checkOutput("reset_tone", 32'(tone_detected), 32'd0);
        checkOutput("reset_timeout", 32'(timeout), 32'd0);

        // Armed with no edges: no timer runs from ARM entry
        reset_n = 1'b1;
        step(450);
        checkOutput("arm_no_timeout", 32'(timeout), 32'd0);
        checkOutput("arm_no_strobe", 32'(strobeCount), 32'd0);

        // Lock on five edges 200 clocks apart
        applyStimulus(200);
        checkOutput("lock_first_edge_no_strobe", 32'(strobeCount), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(200);
            checkOutput("lock_strobe_count", 32'(strobeCount), 32'(k));
            checkOutput("lock_period", 32'(lastPeriod), 32'd200);
            checkOutput("lock_tone", 32'(lastTone), (k == 4) ? 32'd1 : 32'd0);
        end
        checkOutput("edge_to_strobe_latency", 32'(lastStrobeCycle - riseCycle), 32'd4);

        // Tolerance boundary: 202 still matches, 203 drops lock
        applyStimulus(202);
        applyStimulus(203);
        checkOutput("tol_202_period", 32'(lastPeriod), 32'd202);
        checkOutput("tol_202_tone", 32'(lastTone), 32'd1);
        applyStimulus(200);
        checkOutput("tol_203_period", 32'(lastPeriod), 32'd203);
        checkOutput("tol_203_tone", 32'(lastTone), 32'd0);
        checkOutput("tol_203_tone_level", 32'(tone_detected), 32'd0);

        // Re-lock after the mismatch
        applyStimulus(200);
        applyStimulus(200);
        applyStimulus(200);
        checkOutput("relock_third_tone", 32'(tone_detected), 32'd0);
        applyStimulus(200);
        checkOutput("relock_fourth_tone", 32'(tone_detected), 32'd1);

        // Glitch 6 clocks after an accepted edge is ignored
        baseCount = strobeCount;
        glitchPeriod(200);
        checkOutput("glitch_single_strobe", 32'(strobeCount - baseCount), 32'd1);
        applyStimulus(200);
        checkOutput("glitch_next_count", 32'(strobeCount - baseCount), 32'd2);
        checkOutput("glitch_next_period", 32'(lastPeriod), 32'd200);
        checkOutput("glitch_lock_kept", 32'(lastTone), 32'd1);

        // Timeout 400 clocks after the last accepted edge
        baseCount = strobeCount;
        step(220);
        checkOutput("timeout_level", 32'(timeout), 32'd1);
        checkOutput("timeout_tone_drop", 32'(tone_detected), 32'd0);
        checkOutput("timeout_exact_delay", 32'(timeoutCycle - lastStrobeCycle), 32'd400);
        applyStimulus(200);
        checkOutput("timeout_cleared", 32'(timeout), 32'd0);
        checkOutput("timeout_rearm_no_strobe", 32'(strobeCount - baseCount), 32'd0);
        applyStimulus(200);
        checkOutput("timeout_next_strobe", 32'(strobeCount - baseCount), 32'd1);
        checkOutput("timeout_next_period", 32'(lastPeriod), 32'd200);
        checkOutput("timeout_next_tone", 32'(lastTone), 32'd0);

        // Build lock again, then drop enable mid-period
        applyStimulus(200);
        applyStimulus(200);
        applyStimulus(200);
        checkOutput("pre_disable_tone", 32'(tone_detected), 32'd1);
        freq_in = 1'b1;
        step(100);
        enable = 1'b0;
        step(1);
        checkOutput("disable_tone", 32'(tone_detected), 32'd0);
        checkOutput("disable_valid", 32'(period_valid), 32'd0);
        checkOutput("disable_timeout", 32'(timeout), 32'd0);
        checkOutput("disable_period_hold", 32'(period), 32'd200);
        freq_in = 1'b0;
        step(10);
        enable = 1'b1;
        baseCount = strobeCount;
        applyStimulus(200);
        checkOutput("reenable_first_no_strobe", 32'(strobeCount - baseCount), 32'd0);
        applyStimulus(200);
        checkOutput("reenable_second_strobe", 32'(strobeCount - baseCount), 32'd1);
        checkOutput("reenable_period", 32'(lastPeriod), 32'd200);

        // Asynchronous reset pulse mid-period clears at once
        freq_in = 1'b1;
        step(50);
        reset_n = 1'b0;
        #2;
        checkOutput("rst_pulse_period", 32'(period), 32'd0);
        checkOutput("rst_pulse_valid", 32'(period_valid), 32'd0);
        checkOutput("rst_pulse_tone", 32'(tone_detected), 32'd0);
        step(3);
        reset_n = 1'b1;
        freq_in = 1'b0;
        step(10);
        baseCount = strobeCount;
        applyStimulus(200);
        checkOutput("post_rst_first_no_strobe", 32'(strobeCount - baseCount), 32'd0);
        checkOutput("post_rst_period_zero", 32'(period), 32'd0);
        applyStimulus(200);
        checkOutput("post_rst_second_strobe", 32'(strobeCount - baseCount), 32'd1);
        checkOutput("post_rst_period", 32'(lastPeriod), 32'd200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
